// File: rtl/tap_pkg.sv
// tap_pkg: shared state encoding and widths for the tap sequence decoder
package tap_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COUNTING = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;
  localparam int TAP_CNT_W = 3;
endpackage

// File: rtl/tap_sequence_decoder_rise_detect.sv
// rise_detect: delay register resetting to one so a level held through reset yields no edge
module rise_detect (
  input  logic CLOCK,
  input  logic RESET,
  input  logic D,
  output logic RISE
);
  logic d_q;
  always_ff @(posedge CLOCK) d_q <= RESET ? 1'b1 : D;
  assign RISE = D & ~d_q;
endmodule

// File: rtl/tap_sequence_decoder.sv
// tap_sequence_decoder: counts press edges within an inactivity window and reports the tap count
module tap_sequence_decoder
  import tap_pkg::*;
#(
  parameter int WINDOW_CYCLES = 50_000_000,
  parameter int MAX_TAPS = 3,
  parameter int TMR_W = $clog2(WINDOW_CYCLES)
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 PULSE_IN,
  output logic                 TAP_VALID,
  output logic [TAP_CNT_W-1:0] TAP_COUNT,
  output logic                 BUSY
);
  localparam logic [TAP_CNT_W-1:0] MAX_T = TAP_CNT_W'(MAX_TAPS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [1:0] S_START = (MAX_TAPS == 1) ? S_REPORT : S_COUNTING;
  logic rise;
  logic [1:0] state_q, state_d;
  logic [TAP_CNT_W-1:0] taps_q, taps_d, count_q, count_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic valid_q, valid_d, busy_q, busy_d;
  rise_detect u_rise (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .D    (PULSE_IN),
    .RISE (rise)
  );
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      taps_q  <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      taps_q  <= taps_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    taps_d  = taps_q;
    timer_d = timer_q;
    if (state_q == S_COUNTING) begin
      if (rise) begin
        taps_d  = taps_q + 1'b1;
        timer_d = '0;
        state_d = (taps_q + 1'b1 == MAX_T) ? S_REPORT : S_COUNTING;
      end else if (timer_q == TMR_LAST) begin
        state_d = S_REPORT;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else if (rise) begin
      state_d = S_START;
      taps_d  = TAP_CNT_W'(1);
      timer_d = '0;
    end else begin
      state_d = S_IDLE;
    end
  end
  always_comb begin
    valid_d = state_d == S_REPORT;
    busy_d  = state_d == S_COUNTING;
    count_d = valid_d ? taps_d : count_q;
  end
  assign TAP_VALID = valid_q;
  assign TAP_COUNT = count_q;
  assign BUSY      = busy_q;
endmodule

// File: tb/tb_tap_sequence_decoder.sv
// tb_tap_sequence_decoder: directed vector tables plus randomized deadline-model checks
module tb_tap_sequence_decoder;
  localparam int W = 10;
  typedef struct {
    int sc;
    logic r;
    logic p;
    bit ck;
    logic v;
    logic [2:0] c;
    logic b;
    bit ck1;
    logic v1;
    logic [2:0] c1;
    logic b1;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulse = 1'b0;
  logic v3, b3, v1, b1;
  logic [2:0] c3, c1;
  int checks = 0;
  int failures = 0;
  longint g = 0;
  vec_t tv[$];
  bit m_open[2];
  int m_taps[2];
  longint m_rep[2];
  logic [2:0] m_cnt[2];
  logic m_prev[2];
  logic e_v[2];
  logic e_b[2];
  int m_max[2] = '{3, 1};
  always #5 clk = ~clk;
  tap_sequence_decoder #(.WINDOW_CYCLES(W), .MAX_TAPS(3)) u_dut3 (
    .CLOCK(clk), .RESET(rst), .PULSE_IN(pulse), .TAP_VALID(v3), .TAP_COUNT(c3), .BUSY(b3)
  );
  tap_sequence_decoder #(.WINDOW_CYCLES(W), .MAX_TAPS(1)) u_dut1 (
    .CLOCK(clk), .RESET(rst), .PULSE_IN(pulse), .TAP_VALID(v1), .TAP_COUNT(c1), .BUSY(b1)
  );
  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, g, act, exp);
    end
  endtask
  task automatic add(input int sc, input bit r, input bit p, input bit v, input int c, input bit b,
                     input bit ck1, input bit vv1, input int cc1, input bit bb1);
    vec_t e;
    e.sc = sc; e.r = r; e.p = p; e.ck = 1'b1; e.v = v; e.c = 3'(c); e.b = b;
    e.ck1 = ck1; e.v1 = vv1; e.c1 = 3'(cc1); e.b1 = bb1;
    tv.push_back(e);
  endtask
  task automatic add_rst(input int sc, input bit p);
    vec_t e;
    e.sc = sc; e.r = 1'b1; e.p = p; e.ck = 1'b0; e.v = 1'b0; e.c = 3'd0; e.b = 1'b0;
    e.ck1 = 1'b0; e.v1 = 1'b0; e.c1 = 3'd0; e.b1 = 1'b0;
    tv.push_back(e);
  endtask
  task automatic mdl_out();
    for (int d = 0; d < 2; d++) begin
      e_v[d] = 1'b0;
      if (m_open[d] && m_rep[d] == g) begin
        m_open[d] = 1'b0;
        m_cnt[d] = 3'(m_taps[d]);
        e_v[d] = 1'b1;
      end
      e_b[d] = m_open[d];
    end
  endtask
  task automatic mdl_in(input logic r, input logic p);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_open[d] = 1'b0;
        m_cnt[d] = 3'd0;
        m_prev[d] = 1'b1;
      end else begin
        if (p && !m_prev[d]) begin
          if (!m_open[d]) begin
            m_open[d] = 1'b1;
            m_taps[d] = 1;
          end else m_taps[d]++;
          m_rep[d] = (m_taps[d] == m_max[d]) ? g + 1 : g + W + 1;
        end
        m_prev[d] = p;
      end
    end
  endtask
  task automatic cycle(input logic r, input logic p);
    rst = r;
    pulse = p;
    mdl_in(r, p);
    @(posedge clk);
    #1;
    g++;
  endtask
  initial begin
    logic rp;
    int hold;
    add_rst(1, 1'b0);
    for (int t = 0; t <= 30; t++)
      add(1, 0, t >= 5 && t <= 24, t == 16, t >= 16 ? 1 : 0, t >= 6 && t <= 15, 1, t == 6, t >= 6 ? 1 : 0, 0);
    add_rst(2, 1'b0);
    for (int t = 0; t <= 28; t++)
      add(2, 0, t == 5 || t == 12, t == 23, t >= 23 ? 2 : 0, t >= 6 && t <= 22, 1, t == 6 || t == 13, t >= 6 ? 1 : 0, 0);
    add_rst(3, 1'b0);
    for (int t = 0; t <= 30; t++)
      add(3, 0, t == 5 || t == 8 || t == 11, t == 12, t >= 12 ? 3 : 0, t >= 6 && t <= 11,
          1, t == 6 || t == 9 || t == 12, t >= 6 ? 1 : 0, 0);
    add_rst(4, 1'b0);
    for (int t = 0; t <= 32; t++)
      add(4, 0, t == 5 || t == 16, t == 16 || t == 27, t >= 16 ? 1 : 0, (t >= 6 && t <= 15) || (t >= 17 && t <= 26),
          1, t == 6 || t == 17, t >= 6 ? 1 : 0, 0);
    add_rst(5, 1'b0);
    for (int t = 0; t <= 30; t++)
      add(5, 0, t == 5 || t == 15, t == 26, t >= 26 ? 2 : 0, t >= 6 && t <= 25, 1, t == 6 || t == 16, t >= 6 ? 1 : 0, 0);
    add_rst(6, 1'b1);
    for (int t = 0; t <= 25; t++)
      add(6, 0, t <= 20, 0, 0, 0, 1, 0, 0, 0);
    add_rst(7, 1'b0);
    for (int t = 0; t <= 30; t++)
      add(7, t == 10, t == 5 || t == 15, t == 26, t >= 26 ? 1 : 0, (t >= 6 && t <= 10) || (t >= 16 && t <= 25),
          1, t == 6 || t == 16, ((t >= 6 && t <= 10) || t >= 16) ? 1 : 0, 0);
    mdl_in(1'b1, 1'b0);
    @(posedge clk);
    #1;
    g++;
    foreach (tv[i]) begin
      mdl_out();
      if (tv[i].ck) begin
        chk($sformatf("s%0d_valid3", tv[i].sc), 3'(v3), 3'(tv[i].v));
        chk($sformatf("s%0d_count3", tv[i].sc), c3, tv[i].c);
        chk($sformatf("s%0d_busy3", tv[i].sc), 3'(b3), 3'(tv[i].b));
      end
      if (tv[i].ck1) begin
        chk($sformatf("s%0d_valid1", tv[i].sc), 3'(v1), 3'(tv[i].v1));
        chk($sformatf("s%0d_count1", tv[i].sc), c1, tv[i].c1);
        chk($sformatf("s%0d_busy1", tv[i].sc), 3'(b1), 3'(tv[i].b1));
      end
      cycle(tv[i].r, tv[i].p);
    end
    rp = 1'b0;
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      mdl_out();
      chk("rnd_valid3", 3'(v3), 3'(e_v[0]));
      chk("rnd_count3", c3, m_cnt[0]);
      chk("rnd_busy3", 3'(b3), 3'(e_b[0]));
      chk("rnd_valid1", 3'(v1), 3'(e_v[1]));
      chk("rnd_count1", c1, m_cnt[1]);
      chk("rnd_busy1", 3'(b1), 3'(e_b[1]));
      if (hold == 0) begin
        rp = ~rp;
        hold = rp ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 14));
      end
      hold--;
      cycle($urandom_range(0, 299) == 0, rp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
